// File: rtl/bundle_pkg.sv
// bundle_pkg
//   Shared definitions for the bundle restoring stage and related organs:
//   - state_t        : measurement-window FSM states {IDLE, RUN, DONE}
//   - popcount_w(n)  : bit width needed to hold a ones-count of an n-bit bundle
//   - BUNDLE_WIDTH_DEF / CNT_WIDTH_DEF : default bundle and counter widths
package bundle_pkg;

  localparam int BUNDLE_WIDTH_DEF = 9;
  localparam int CNT_WIDTH_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int popcount_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bundle_popcount.sv
// bundle_popcount
//   Combinational ones-count of a redundant bundle plus the size of the
//   minority (the number of replicas that disagree with the majority).
//   Ports:
//     bundle   in  BUNDLE_WIDTH : redundant gate outputs
//     ones     out PW           : number of ones in bundle
//     minority out PW           : min(ones, BUNDLE_WIDTH - ones)
module bundle_popcount
  import bundle_pkg::*;
#(
  parameter int BUNDLE_WIDTH = BUNDLE_WIDTH_DEF,
  localparam int PW = popcount_w(BUNDLE_WIDTH)
) (
  input  logic [BUNDLE_WIDTH-1:0] bundle,
  output logic [PW-1:0]           ones,
  output logic [PW-1:0]           minority
);

  logic [PW-1:0] zeros;

  always_comb begin
    ones = '0;
    for (int i = 0; i < BUNDLE_WIDTH; i++) begin
      ones = ones + PW'(bundle[i]);
    end
    zeros    = PW'(BUNDLE_WIDTH) - ones;
    minority = (ones < zeros) ? ones : zeros;
  end

endmodule

// File: rtl/bundle_restorer.sv
// bundle_restorer
//   Two-stage valid/ready restoring stage: each accepted bundle of redundant
//   NAND outputs is majority-voted to one restored bit. Optional windowed
//   error statistics are compiled in with the macro BUNDLE_RESTORER_STATS_EN;
//   without it done_o and all counter outputs are tied to 0.
//   Ports:
//     clk, reset_n        : clock (rising edge), asynchronous active-low reset
//     valid_i, bundle_i   : input bundle and its valid
//     ready_o             : stage accepts a bundle this cycle
//     z_o, valid_o        : restored bit and its valid
//     ready_i             : consumer accepts z_o
//     start_i             : pulse opening a measurement window
//     window_len_i        : results per window, sampled on start_i
//     done_o              : window complete, counters frozen
//     samples_o           : results counted in the window
//     errored_o           : non-unanimous results counted
//     minority_o          : summed minority bits
module bundle_restorer
  import bundle_pkg::*;
#(
  parameter int BUNDLE_WIDTH = BUNDLE_WIDTH_DEF,
  parameter int THRESHOLD    = (BUNDLE_WIDTH + 1) / 2,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    valid_i,
  input  logic [BUNDLE_WIDTH-1:0] bundle_i,
  output logic                    ready_o,
  output logic                    z_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  input  logic                    start_i,
  input  logic [CNT_WIDTH-1:0]    window_len_i,
  output logic                    done_o,
  output logic [CNT_WIDTH-1:0]    samples_o,
  output logic [CNT_WIDTH-1:0]    errored_o,
  output logic [CNT_WIDTH-1:0]    minority_o
);

  localparam int PW = popcount_w(BUNDLE_WIDTH);

  logic                    advance;
  logic [BUNDLE_WIDTH-1:0] bundle_p0;
  logic                    vld_p0;
  logic [PW-1:0]           ones_c;
  logic [PW-1:0]           min_c;
  logic                    z_p1;
  logic [PW-1:0]           min_p1;
  logic                    vld_p1;

  // Whole pipeline moves together; it only holds when the output is stalled.
  assign advance = ~vld_p1 | ready_i;
  assign ready_o = advance;

  // Stage 0: capture the incoming bundle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bundle_p0 <= '0;
      vld_p0    <= 1'b0;
    end else if (advance) begin
      bundle_p0 <= bundle_i;
      vld_p0    <= valid_i;
    end
  end

  bundle_popcount #(
    .BUNDLE_WIDTH (BUNDLE_WIDTH)
  ) u_popcount (
    .bundle   (bundle_p0),
    .ones     (ones_c),
    .minority (min_c)
  );

  // Stage 1: majority vote and minority size
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z_p1   <= 1'b0;
      min_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (advance) begin
      z_p1   <= (ones_c >= PW'(THRESHOLD));
      min_p1 <= min_c;
      vld_p1 <= vld_p0;
    end
  end

  assign z_o     = z_p1;
  assign valid_o = vld_p1;

`ifdef BUNDLE_RESTORER_STATS_EN

  localparam int SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;

  // Saturating add of a minority count into a statistics counter.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [PW-1:0]        b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s > SW'({CNT_WIDTH{1'b1}})) return {CNT_WIDTH{1'b1}};
    return s[CNT_WIDTH-1:0];
  endfunction

  state_t               state_q;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] samples_q;
  logic [CNT_WIDTH-1:0] errored_q;
  logic [CNT_WIDTH-1:0] minority_q;
  logic                 xfer;

  assign xfer = vld_p1 & ready_i;

  // The window closes on the edge after samples reaches the length, so a
  // transfer coinciding with that edge is deliberately not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      samples_q  <= '0;
      errored_q  <= '0;
      minority_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q    <= RUN;
            len_q      <= window_len_i;
            samples_q  <= '0;
            errored_q  <= '0;
            minority_q <= '0;
          end
        end
        RUN: begin
          if (samples_q == len_q) begin
            state_q <= DONE;
          end else if (xfer) begin
            samples_q  <= sat_add(samples_q, PW'(1));
            if (min_p1 != '0) errored_q <= sat_add(errored_q, PW'(1));
            minority_q <= sat_add(minority_q, min_p1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done_o     = (state_q == DONE);
  assign samples_o  = samples_q;
  assign errored_o  = errored_q;
  assign minority_o = minority_q;

`else

  logic unused_stats;
  assign unused_stats = ^{start_i, window_len_i, min_p1};

  assign done_o     = 1'b0;
  assign samples_o  = '0;
  assign errored_o  = '0;
  assign minority_o = '0;

`endif

endmodule

// File: tb/tb_bundle_restorer.sv
module tb_bundle_restorer;

`ifdef BUNDLE_RESTORER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_i;
  logic [8:0]  bundle_i;
  logic        ready_i;
  logic        start_m;
  logic        start_s;
  logic [15:0] window_len;
  logic [3:0]  window_len_s;

  logic        ready_o, z_o, valid_o, done_o;
  logic [15:0] samples_o, errored_o, minority_o;

  logic        s_ready_o, s_z_o, s_valid_o, s_done_o;
  logic [3:0]  s_samples_o, s_errored_o, s_minority_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bundle_restorer u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid_i      (valid_i),
    .bundle_i     (bundle_i),
    .ready_o      (ready_o),
    .z_o          (z_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .start_i      (start_m),
    .window_len_i (window_len),
    .done_o       (done_o),
    .samples_o    (samples_o),
    .errored_o    (errored_o),
    .minority_o   (minority_o)
  );

  bundle_restorer #(.CNT_WIDTH(4)) u_sat (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid_i      (valid_i),
    .bundle_i     (bundle_i),
    .ready_o      (s_ready_o),
    .z_o          (s_z_o),
    .valid_o      (s_valid_o),
    .ready_i      (ready_i),
    .start_i      (start_s),
    .window_len_i (window_len_s),
    .done_o       (s_done_o),
    .samples_o    (s_samples_o),
    .errored_o    (s_errored_o),
    .minority_o   (s_minority_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ones_n(input int k);
    logic [9:0] t;
    t = (10'd1 << k) - 10'd1;
    return t[8:0];
  endfunction

  task automatic single(input string tag, input logic [8:0] b, input logic ez, input logic [3:0] em);
    valid_i  = 1'b1;
    bundle_i = b;
    @(negedge clk);
    valid_i  = 1'b0;
    bundle_i = '0;
    @(negedge clk);
    chk({tag, "_vld"}, 32'(valid_o), 32'(1'b1));
    chk({tag, "_z"}, 32'(z_o), 32'(ez));
    chk({tag, "_min"}, 32'(u_dut.min_p1), 32'(em));
    @(negedge clk);
    chk({tag, "_bubble"}, 32'(valid_o), 32'(1'b0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] rx_q[$];
    int         k;
    bit         acc_in;
    logic       z_hold;

    reset_n      = 1'b0;
    valid_i      = 1'b0;
    bundle_i     = '0;
    ready_i      = 1'b1;
    start_m      = 1'b0;
    start_s      = 1'b0;
    window_len   = '0;
    window_len_s = '0;
    z_hold       = 1'b0;

    // Reset state
    #12;
    chk("rst_z", 32'(z_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_samples", 32'(samples_o), 32'd0);
    chk("rst_minority", 32'(minority_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single bundles through the pipeline
    single("b3",   9'b000000111, 1'b0, 4'd3);
    single("b5",   9'b111110000, 1'b1, 4'd4);
    single("b9",   9'h1FF,       1'b1, 4'd0);
    single("b4",   9'b101010100, 1'b0, 4'd4);

    // Continuous stream with a 4-cycle output stall
    k      = 0;
    acc_in = 1'b0;
    for (int cyc = 0; cyc < 40 && rx_q.size() < 9; cyc++) begin
      @(negedge clk);
      if (acc_in) k++;
      valid_i  = (k < 9);
      bundle_i = (k < 9) ? ones_n(k) : 9'd0;
      ready_i  = !(cyc >= 4 && cyc < 8);
      #1;
      acc_in = valid_i && ready_o;
      if (valid_o && ready_i) rx_q.push_back({z_o, u_dut.min_p1});
      if (!ready_i) begin
        chk("stall_ready", 32'(ready_o), 32'd0);
        chk("stall_valid", 32'(valid_o), 32'd1);
        if (cyc == 4) z_hold = z_o;
        else chk("stall_z", 32'(z_o), 32'(z_hold));
      end
    end
    valid_i  = 1'b0;
    bundle_i = '0;
    ready_i  = 1'b1;
    chk("stream_count", 32'(rx_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      logic [3:0] em;
      em = (i < 9 - i) ? 4'(i) : 4'(9 - i);
      chk($sformatf("stream_item%0d", i), 32'(rx_q[i]), 32'({(i >= 5), em}));
    end
    repeat (3) @(negedge clk);
    chk("flush_valid", 32'(valid_o), 32'd0);

    // Window of length 4: bundles with 9, 8, 4, 0 ones, then two extra
    start_m    = 1'b1;
    window_len = 16'd4;
    @(negedge clk);
    start_m  = 1'b0;
    valid_i  = 1'b1;
    bundle_i = 9'h1FF;
    @(negedge clk);
    bundle_i = ones_n(8);
    @(negedge clk);
    bundle_i = ones_n(4);
    @(negedge clk);
    bundle_i = ones_n(0);
    @(negedge clk);
    bundle_i = ones_n(5);
    chk("win_samples_mid", 32'(samples_o), STATS ? 32'd2 : 32'd0);
    chk("win_errored_mid", 32'(errored_o), STATS ? 32'd1 : 32'd0);
    chk("win_minority_mid", 32'(minority_o), STATS ? 32'd1 : 32'd0);
    @(negedge clk);
    bundle_i = ones_n(3);
    @(negedge clk);
    valid_i  = 1'b0;
    bundle_i = '0;
    chk("win_samples", 32'(samples_o), STATS ? 32'd4 : 32'd0);
    chk("win_errored", 32'(errored_o), STATS ? 32'd2 : 32'd0);
    chk("win_minority", 32'(minority_o), STATS ? 32'd5 : 32'd0);
    chk("win_done_early", 32'(done_o), 32'd0);
    @(negedge clk);
    chk("win_done", 32'(done_o), STATS ? 32'd1 : 32'd0);
    repeat (2) @(negedge clk);
    chk("win_frozen_samples", 32'(samples_o), STATS ? 32'd4 : 32'd0);
    chk("win_frozen_errored", 32'(errored_o), STATS ? 32'd2 : 32'd0);
    chk("win_frozen_minority", 32'(minority_o), STATS ? 32'd5 : 32'd0);
    chk("win_frozen_done", 32'(done_o), STATS ? 32'd1 : 32'd0);

    // Saturation with 4-bit counters: 20 bundles of minority 3, window 15
    start_s      = 1'b1;
    window_len_s = 4'd15;
    @(negedge clk);
    start_s = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (j == 9) begin
        chk("sat_samples_mid", 32'(s_samples_o), STATS ? 32'd7 : 32'd0);
        chk("sat_minority_mid", 32'(s_minority_o), STATS ? 32'd15 : 32'd0);
      end
      valid_i  = 1'b1;
      bundle_i = ones_n(3);
      @(negedge clk);
    end
    valid_i  = 1'b0;
    bundle_i = '0;
    repeat (5) @(negedge clk);
    chk("sat_samples", 32'(s_samples_o), STATS ? 32'd15 : 32'd0);
    chk("sat_errored", 32'(s_errored_o), STATS ? 32'd15 : 32'd0);
    chk("sat_minority", 32'(s_minority_o), STATS ? 32'd15 : 32'd0);
    chk("sat_done", 32'(s_done_o), STATS ? 32'd1 : 32'd0);

    // Asynchronous reset mid-window with a stalled result in flight
    start_m    = 1'b1;
    window_len = 16'd10;
    @(negedge clk);
    start_m  = 1'b0;
    valid_i  = 1'b1;
    bundle_i = 9'h1FF;
    repeat (4) @(negedge clk);
    ready_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_samples", 32'(samples_o), STATS ? 32'd2 : 32'd0);
    chk("pre_rst_z", 32'(z_o), 32'd1);
    chk("pre_rst_valid", 32'(valid_o), 32'd1);
    chk("pre_rst_ready", 32'(ready_o), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_z", 32'(z_o), 32'd0);
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_ready", 32'(ready_o), 32'd1);
    chk("arst_done", 32'(done_o), 32'd0);
    chk("arst_samples", 32'(samples_o), 32'd0);
    chk("arst_errored", 32'(errored_o), 32'd0);
    chk("arst_minority", 32'(minority_o), 32'd0);
    @(negedge clk);
    reset_n  = 1'b1;
    valid_i  = 1'b0;
    bundle_i = '0;
    ready_i  = 1'b1;
    @(negedge clk);
    single("post_rst", ones_n(3), 1'b0, 4'd3);
    repeat (2) @(negedge clk);
    chk("idle_samples", 32'(samples_o), 32'd0);
    chk("idle_minority", 32'(minority_o), 32'd0);
    chk("idle_done", 32'(done_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bundle_restorer.md
# bundle_restorer

Restoring stage placed directly downstream of a bank of replicated erroneous NAND gates. Each cycle it can accept one bundle of redundant gate outputs and majority-votes it to a single restored bit over a two-stage valid/ready pipeline. Optionally it gathers windowed error statistics (non-unanimous bundles, minority-bit totals) so a campaign can measure effective gate error rates against `ERROR_PROBABILITY`.

## Interface
- `BUNDLE_WIDTH`, 9: number of redundant wires per bundle; odd, 3..63.
- `THRESHOLD`, (BUNDLE_WIDTH+1)/2: restored bit is 1 when the ones-count is at least this value; 1..BUNDLE_WIDTH.
- `CNT_WIDTH`, 16: width of the statistics counters and the window length.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `valid_i` in 1: bundle present.
- `bundle_i` in BUNDLE_WIDTH: redundant gate outputs, one bit per replica.
- `ready_o` out 1: stage can accept a bundle this cycle.
- `z_o` out 1: restored bit.
- `valid_o` out 1: `z_o` is valid.
- `ready_i` in 1: consumer accepts `z_o`.
- `start_i` in 1: one-cycle pulse that opens a measurement window.
- `window_len_i` in CNT_WIDTH: results per window, sampled on `start_i`.
- `done_o` out 1: window complete, counters frozen.
- `samples_o`, `errored_o`, `minority_o` out CNT_WIDTH each: results counted, non-unanimous results, and summed minority bits.

## Operation
- `advance = ~valid_o | ready_i`; `ready_o = advance`. All pipeline registers hold while `advance` is 0.
- Stage 1, on `advance`: captures `bundle_i` and valid bit `v1 <= valid_i`.
- Stage 2, on `advance`: `ones = popcount(stage-1 bundle)` at width $clog2(BUNDLE_WIDTH+1). Registers `z_o = (ones >= THRESHOLD)`, `minority = min(ones, BUNDLE_WIDTH-ones)` and `valid_o <= v1`.
- Transfer: `valid_o & ready_i`. Statistics update only on a transfer.
- FSM states:
  - IDLE: reset state. `start_i` clears all counters, latches `window_len_i`, goes to RUN.
  - RUN: on each transfer, `samples +1`, `errored +1` if `minority != 0`, `minority_o += minority`. When `samples` equals the latched length, go to DONE. A latched length of 0 goes to DONE the cycle after entering RUN.
  - DONE: `done_o = 1` and counters are frozen. `start_i` clears the counters, relatches the length and goes to RUN.
- `start_i` in RUN is ignored.
- All counters saturate at all-ones and never wrap.
- The pipeline runs in every FSM state; only counting is gated.

## Timing
- Latency: a bundle accepted at edge n appears on `z_o`/`valid_o` after edge n+2 with no stall. Throughput is 1 per cycle.
- Under stall (`valid_o=1`, `ready_i=0`), `z_o` and `valid_o` are stable and `ready_o=0`.
- Reset values: `z_o=0`, `valid_o=0`, `ready_o=1`, `done_o=0`, all counters 0, FSM in IDLE, `v1=0`.
- Reset asserted mid-window or mid-stall discards all in-flight data and counts immediately, asynchronously.
- `done_o` rises the cycle after the final counted transfer.
- Counter outputs are registered and reflect transfers up to the previous edge.

## Configuration
- `BUNDLE_RESTORER_STATS_EN` defined: the FSM and counters are present as described.
- Not defined: FSM and counters are removed. `done_o` and all counter outputs are tied to 0, and `start_i`/`window_len_i` are ignored. Pipeline behaviour is identical either way.

## Structure
- Shared package `bundle_pkg` holds:
  - the FSM state enum `{IDLE, RUN, DONE}`;
  - a `popcount_w(n)` constant function for widths;
  - default constants for bundle width and counter width.
- One sub-module, `bundle_popcount`: combinational ones-count plus minority computation, parameterised by BUNDLE_WIDTH. It is reused by future multiplexed restoring organs.

## Test plan
- Bundle `9'b000000111` (3 ones), `ready_i=1` → `z_o=0` two cycles later, minority 3.
- Bundle `9'b111110000` (5 ones) → `z_o=1`. Bundle `9'h1FF` → `z_o=1`, minority 0, not counted as errored.
- Stall: hold `ready_i=0` for 4 cycles with a continuous stream → `ready_o=0`, `z_o` stable, no loss or duplication after release.
- Window of length 4 with bundles of 9, 8, 4 and 0 ones → `samples=4`, `errored=2`, `minority=5`, `done_o=1`. A fifth transfer leaves the counters unchanged.
- Set `CNT_WIDTH=4` and stream 20 non-unanimous bundles in a length-15 window → counters stop at 15, no wrap.
- Assert `reset_n` low mid-window with data in flight → all outputs return to reset values at once, and the FSM is in IDLE after release.
